// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
//   Loadable WIDTH-bit down-counter/timer. A load captures data_in into both
//   the live count and a reload register; while enabled the count decrements
//   once per clock until it reaches the terminal value, where a one-cycle tc
//   pulse is issued. Clearing en pauses the count without losing it.
//
//   Build option (macro AUTO_RELOAD_EN):
//     defined   - periodic timer: the terminal edge reloads count from
//                 reload_reg and the counter keeps running.
//     undefined - one-shot timer: the terminal edge clears count and the
//                 counter returns to idle.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous reset, active-high
//   load     in   1      load data_in into count and reload_reg
//   data_in  in   WIDTH  load value
//   en       in   1      decrement enable (low = pause)
//   count    out  WIDTH  current count, registered
//   zero     out  1      registered, high when count == 0
//   tc       out  1      terminal-count pulse, one cycle wide
//   busy     out  1      registered, high while running or paused
// ---------------------------------------------------------------------------
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;

  logic [1:0]       next_state;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] next_reload;
  logic             next_tc;

  // Next-state logic. Load outranks enable, so a load arriving on the
  // terminal edge replaces the count and suppresses that tc. Idle ignores en,
  // which is what keeps the count from ever wrapping below zero.
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_reload = reload_reg;
    next_tc     = 1'b0;

    if (load) begin
      next_count  = data_in;
      next_reload = data_in;
      if (data_in == '0)
        next_state = IDLE;
      else if (en)
        next_state = RUN;
      else
        next_state = PAUSE;
    end else if (state != IDLE) begin
      if (!en) begin
        next_state = PAUSE;
      end else if (count == WIDTH'(1)) begin
        next_tc = 1'b1;
`ifdef AUTO_RELOAD_EN
        next_count = reload_reg;
        next_state = RUN;
`else
        next_count = '0;
        next_state = IDLE;
`endif
      end else begin
        next_count = count - WIDTH'(1);
        next_state = RUN;
      end
    end
  end

  // State and output registers. zero and busy are derived from the values
  // being loaded, so they always agree with count and state on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      zero       <= 1'b1;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= next_count;
      reload_reg <= next_reload;
      zero       <= (next_count == '0);
      tc         <= next_tc;
      busy       <= (next_state != IDLE);
    end
  end

endmodule
